fifo_mem_core: RTL
==================

// Module: fifo_mem_core
// PURPOSE
//  Single-clock, FIFO-mode memory core. This is the design under test that sits between the
//    A-QED checker's write-side output (data_in/wen) and its read-side capture (data_out/valid_out).
//  Provides wen/ren push/pop with 1-cycle read latency and an empty-FIFO write-through bypass.
//  Provides clk_en gating and a synchronous flush.
//  Its empty/full/valid_out timing is the contract the checker's out-count logic relies on.
// PARAMETERS
//  DATA_WIDTH  16   width of data_in/data_out
//  DEPTH       128  number of entries; must be a power of 2, >= 2
//  ADDR_WIDTH  $clog2(DEPTH)  derived; pointers are ADDR_WIDTH+1 bits (wrap bit)
// PORTS
//  clk        in   1              clock
//  reset      in   1              synchronous, active-high
//  clk_en     in   1              state-update enable; 0 = hold all state and outputs
//  flush      in   1              synchronous clear of contents (honoured only when clk_en=1)
//  wen        in   1              push request
//  ren        in   1              pop request
//  data_in    in   DATA_WIDTH     push data
//  data_out   out  DATA_WIDTH     registered pop data
//  valid_out  out  1              data_out valid this cycle (1-cycle pulse per pop/bypass)
//  empty      out  1              count==0 (from registered count)
//  full       out  1              count==DEPTH (from registered count)
//  count      out  ADDR_WIDTH+1   current occupancy
//  error      out  1              sticky: write dropped while full, or read of empty without write
// BEHAVIOUR
//  Reset values: data_out=0, valid_out=0, count=0, empty=1, full=0, error=0, wr_ptr=rd_ptr=0.
//  clk_en=0: no pointer, count, data_out, valid_out or error change.
//    wen/ren/flush are ignored, and flush is not deferred.
//  Priority per clk_en cycle: reset > flush > pop/push.
//  Flush:
//    - wr_ptr=rd_ptr=count=0 and valid_out=0 next cycle.
//    - data_out holds; any wen/ren in the same cycle is discarded.
//    - error is unchanged.
//  Pop: ren & ~empty.
//    - mem[rd_ptr] appears on data_out the next cycle with valid_out=1.
//    - rd_ptr increments.
//  Push: wen & (~full | ren).
//    - data_in is written to mem[wr_ptr]; wr_ptr increments.
//    - When full, a simultaneous pop frees the slot, so both are accepted.
//  Bypass: wen & ren & empty.
//    - data_in goes to data_out next cycle with valid_out=1.
//    - Nothing is written; pointers and count are unchanged; empty stays 1.
//  Count: +1 on push only, -1 on pop only, unchanged on push+pop or bypass.
//  valid_out=0 on any clk_en cycle with no pop and no bypass; data_out then holds its last value.
//  Ordering: strict FIFO. Pointers wrap modulo 2*DEPTH.
//    - full when the pointer MSBs differ and the lower bits are equal.
//    - The count register must agree with the pointer difference; this is checked by an assertion.
//  error: set on wen & full & ~ren, or on ren & empty & ~wen (with clk_en, ~flush).
//    - Cleared only by reset.
//  Reset asserted mid-operation: all contents are abandoned, the reset values hold next cycle,
//    and any in-flight pop is discarded (valid_out=0).
// STRUCTURE
//  Package fifo_core_pkg:
//    - DATA_WIDTH default;
//    - a clog2 helper;
//    - a typedef for the ptr_t (ADDR_WIDTH+1) pointer type.
//  Sub-module fifo_sram_array:
//    - DEPTH x DATA_WIDTH register array;
//    - one write port (we, waddr, wdata);
//    - one synchronous read port (re, raddr, rdata registered).
//  Top level holds the pointers, count, flags, bypass mux and error.
// TESTING (DEPTH=4, DATA_WIDTH=16)
//  1. Reset for 2 cycles -> empty=1, full=0, valid_out=0, data_out=0, count=0, error=0.
//  2. Push 0x0001..0x0004, then push 0x0005 -> full=1 after the 4th push, 0x0005 dropped, error=1.
//     Then pop 4 times -> 1,2,3,4, each one cycle after ren with valid_out=1; empty=1 after the last.
//  3. Empty; wen=ren=1, data_in=0xBEEF -> next cycle data_out=0xBEEF, valid_out=1,
//     count=0, empty=1, error=0.
//  4. Full with 0x0001..0x0004; wen=ren=1, data_in=0xAAAA -> data_out=0x0001, count stays 4.
//     Subsequent pops give 2,3,4,0xAAAA.
//  5. After 3 pushes, assert flush with wen=ren=1 -> next cycle count=0, empty=1, valid_out=0.
//     A following pop of empty sets error=1, and data_out is unchanged.
//  6. Hold clk_en=0 for 3 cycles while toggling wen/ren/flush -> all outputs frozen.
//     Then do 10 interleaved push/pop with clk_en=1 -> order preserved across pointer wrap.

Source files
------------

// File: rtl/fifo_mem_core_pkg.sv
// Shared parameters, width helper and pointer type for the FIFO memory core.
package fifo_core_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 128;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  localparam int DEFAULT_ADDR_WIDTH = clog2(DEFAULT_DEPTH);

  // Extra MSB is the wrap bit that tells full apart from empty.
  typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/fifo_mem_core_if.sv
// Push/pop, control and status bundle between a FIFO user (master) and the core (slave).
interface fifo_mem_core_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
);
  logic                  clk_en;
  logic                  flush;
  logic                  wen;
  logic                  ren;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  error;

  modport master (
    output clk_en, flush, wen, ren, data_in,
    input  data_out, valid_out, empty, full, count, error
  );

  modport slave (
    input  clk_en, flush, wen, ren, data_in,
    output data_out, valid_out, empty, full, count, error
  );
endinterface

// File: rtl/fifo_mem_core_sram_array.sv
// DEPTH x DATA_WIDTH register array: one write port, one read port with registered data.
module fifo_sram_array #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Same-address read and write return the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_mem_core.sv
// Single-clock FIFO core: 1-cycle pop latency, empty write-through bypass, clk_en hold, flush.
module fifo_mem_core
  import fifo_core_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input logic             clk,
  input logic             reset,
  fifo_mem_core_if.slave  io
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  valid_q, valid_d, error_q, error_d;
  logic                  src_byp_q, src_byp_d;
  logic [DATA_WIDTH-1:0] byp_q, byp_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  empty, full, pop, push, bypass, mem_we, mem_re;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);
  assign pop    = io.ren & ~empty;
  assign bypass = io.wen & io.ren & empty;
  assign push   = io.wen & (~full | io.ren) & ~bypass;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    valid_d   = valid_q;
    error_d   = error_q;
    src_byp_d = src_byp_q;
    byp_d     = byp_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (io.clk_en) begin
      valid_d = 1'b0;
      if (io.flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          mem_re    = ~reset;
          valid_d   = 1'b1;
          src_byp_d = 1'b0;
        end
        if (bypass) begin
          valid_d   = 1'b1;
          src_byp_d = 1'b1;
          byp_d     = io.data_in;
        end
        if (push) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          mem_we   = ~reset;
        end
        if (push && !pop)      count_d = count_q + PTR_ONE;
        else if (pop && !push) count_d = count_q - PTR_ONE;
        if ((io.wen & full & ~io.ren) | (io.ren & empty & ~io.wen)) error_d = 1'b1;
      end
    end
  end

  // Reset selects the zeroed bypass register so data_out reads 0 without clearing the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      src_byp_q <= 1'b1;
      byp_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      src_byp_q <= src_byp_d;
      byp_q     <= byp_d;
    end
  end

  fifo_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (io.data_in),
    .re    (mem_re),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  assign io.data_out  = src_byp_q ? byp_q : mem_rdata;
  assign io.valid_out = valid_q;
  assign io.empty     = empty;
  assign io.full      = full;
  assign io.count     = count_q;
  assign io.error     = error_q;

  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
    count_q == ADDR_WIDTH'(0) + (wr_ptr_q - rd_ptr_q));

endmodule
